// File: rtl/data_mem_resp.sv
// Data-memory responder for the write-back stage: one outstanding read or write,
// fixed read/write latencies, out-of-range and conflicting requests flagged on out_err.
module data_mem_resp #(
    parameter int DEPTH     = 256,
    parameter int ADDR_BITS = 8,
    parameter int RD_LAT    = 2,
    parameter int WR_LAT    = 1
) (
    input  logic        CLOCK,
    input  logic        in_rst,
    input  logic        in_cntrl_mem_read,
    input  logic        in_cntrl_mem_write,
    input  logic [15:0] in_addr_mem,
    input  logic [15:0] in_data_mem,
    output logic [15:0] out_rd_data,
    output logic        out_rd_valid,
    output logic        out_busy,
    output logic        out_err
);

    typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT} state_t;

    localparam logic [2:0] RD_CNT = 3'(RD_LAT - 1);
    localparam logic [2:0] WR_CNT = 3'(WR_LAT - 1);

    state_t                 state_q;
    logic [2:0]             cnt_q;
    logic [ADDR_BITS-1:0]   idx_q;
    logic                   oor_q;
    logic [15:0]            wdata_q;
    logic [15:0]            mem_q [DEPTH];
    logic [15:0]            rd_data_q;
    logic                   rd_valid_q;
    logic                   busy_q;
    logic                   err_q;

    logic                   req_in_range;
    logic [ADDR_BITS-1:0]   req_idx;

    // Any set bit above the word index puts the request outside the array.
    assign req_in_range = ((in_addr_mem >> ADDR_BITS) == 16'd0);
    assign req_idx      = in_addr_mem[ADDR_BITS-1:0];

    always_ff @(posedge CLOCK) begin
        if (in_rst) begin
            state_q    <= IDLE;
            cnt_q      <= 3'd0;
            idx_q      <= '0;
            oor_q      <= 1'b0;
            wdata_q    <= 16'h0000;
            rd_data_q  <= 16'h0000;
            rd_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= 16'h0000;
        end else begin
            rd_valid_q <= 1'b0;
            err_q      <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (in_cntrl_mem_read ^ in_cntrl_mem_write) begin
                        idx_q   <= req_idx;
                        oor_q   <= ~req_in_range;
                        wdata_q <= in_data_mem;
                        busy_q  <= 1'b1;
                        if (in_cntrl_mem_read) begin
                            cnt_q   <= RD_CNT;
                            state_q <= RD_WAIT;
                        end else begin
                            cnt_q   <= WR_CNT;
                            state_q <= WR_WAIT;
                        end
                    end else if (in_cntrl_mem_read && in_cntrl_mem_write) begin
                        err_q <= 1'b1;
                    end
                end
                RD_WAIT: begin
                    if (cnt_q == 3'd0) begin
                        rd_valid_q <= 1'b1;
                        rd_data_q  <= oor_q ? 16'h0000 : mem_q[idx_q];
                        err_q      <= oor_q;
                        busy_q     <= 1'b0;
                        state_q    <= IDLE;
                    end else begin
                        cnt_q <= cnt_q - 3'd1;
                    end
                end
                WR_WAIT: begin
                    if (cnt_q == 3'd0) begin
                        if (!oor_q) mem_q[idx_q] <= wdata_q;
                        err_q   <= oor_q;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q - 3'd1;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign out_rd_data  = rd_data_q;
    assign out_rd_valid = rd_valid_q;
    assign out_busy     = busy_q;
    assign out_err      = err_q;

endmodule

// File: tb/tb_data_mem_resp.sv
// Bench for data_mem_resp: directed scenarios with literal expectations, then random
// traffic, all outputs compared every cycle against a transaction-level model.
module tb_data_mem_resp;

    localparam int RD_LAT = 2;
    localparam int WR_LAT = 3;

    logic        CLOCK = 1'b0;
    logic        in_rst = 1'b1;
    logic        in_cntrl_mem_read = 1'b0;
    logic        in_cntrl_mem_write = 1'b0;
    logic [15:0] in_addr_mem = 16'h0000;
    logic [15:0] in_data_mem = 16'h0000;
    logic [15:0] out_rd_data;
    logic        out_rd_valid;
    logic        out_busy;
    logic        out_err;

    int checks = 0;
    int errors = 0;

    data_mem_resp #(.DEPTH(256), .ADDR_BITS(8), .RD_LAT(RD_LAT), .WR_LAT(WR_LAT)) dut (
        .CLOCK             (CLOCK),
        .in_rst            (in_rst),
        .in_cntrl_mem_read (in_cntrl_mem_read),
        .in_cntrl_mem_write(in_cntrl_mem_write),
        .in_addr_mem       (in_addr_mem),
        .in_data_mem       (in_data_mem),
        .out_rd_data       (out_rd_data),
        .out_rd_valid      (out_rd_valid),
        .out_busy          (out_busy),
        .out_err           (out_err)
    );

    always #5 CLOCK = ~CLOCK;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: edge numbers at which each response is due.
    int          cyc = 0;
    int          busy_end = 0;
    int          valid_at = -1;
    int          err_at = -1;
    logic [15:0] rd_pending = 16'h0000;
    logic [15:0] m_data = 16'h0000;
    logic [15:0] m_mem [256];

    initial for (int i = 0; i < 256; i++) m_mem[i] = 16'h0000;

    always @(posedge CLOCK) begin
        logic inr;
        cyc++;
        inr = (in_addr_mem[15:8] == 8'h00);
        if (in_rst) begin
            for (int i = 0; i < 256; i++) m_mem[i] = 16'h0000;
            busy_end = cyc;
            valid_at = -1;
            err_at   = -1;
            m_data   = 16'h0000;
        end else begin
            if (valid_at == cyc) m_data = rd_pending;
            if (cyc > busy_end) begin
                if (in_cntrl_mem_read && in_cntrl_mem_write) begin
                    err_at = cyc;
                end else if (in_cntrl_mem_read) begin
                    busy_end   = cyc + RD_LAT;
                    valid_at   = cyc + RD_LAT;
                    rd_pending = inr ? m_mem[in_addr_mem[7:0]] : 16'h0000;
                    if (!inr) err_at = cyc + RD_LAT;
                end else if (in_cntrl_mem_write) begin
                    busy_end = cyc + WR_LAT;
                    // Nothing can observe the array while busy, so commit now.
                    if (inr) m_mem[in_addr_mem[7:0]] = in_data_mem;
                    else     err_at = cyc + WR_LAT;
                end
            end
        end
    end

    always @(negedge CLOCK) begin
        if (cyc > 0) begin
            chk("rd_data", out_rd_data, m_data);
            chk("rd_valid", {15'd0, out_rd_valid}, {15'd0, valid_at == cyc});
            chk("busy", {15'd0, out_busy}, {15'd0, cyc < busy_end});
            chk("err", {15'd0, out_err}, {15'd0, err_at == cyc});
        end
    end

    task automatic drive(input logic rd, input logic wr, input logic [15:0] a, input logic [15:0] d);
        in_cntrl_mem_read  = rd;
        in_cntrl_mem_write = wr;
        in_addr_mem        = a;
        in_data_mem        = d;
    endtask

    // One-cycle request; returns at the negedge just after the accept edge.
    task automatic req(input logic rd, input logic wr, input logic [15:0] a, input logic [15:0] d);
        @(negedge CLOCK);
        drive(rd, wr, a, d);
        @(negedge CLOCK);
        drive(1'b0, 1'b0, 16'h0000, 16'h0000);
    endtask

    task automatic idle_wait(input string name);
        int n = 0;
        while (out_busy && n < 20) begin
            @(negedge CLOCK);
            n++;
        end
        if (n >= 20) begin
            checks++;
            errors++;
            $display("FAIL %s: busy stuck high, expected idle within 20 cycles", name);
        end
    endtask

    task automatic do_reset(input logic with_req);
        @(negedge CLOCK);
        in_rst = 1'b1;
        drive(with_req, 1'b0, 16'h0001, 16'h0000);
        @(negedge CLOCK);
        in_rst = 1'b0;
        drive(1'b0, 1'b0, 16'h0000, 16'h0000);
    endtask

    initial begin
        do_reset(1'b1);
        chk("rst_busy", {15'd0, out_busy}, 16'h0000);
        chk("rst_data", out_rd_data, 16'h0000);

        // write then read back
        req(1'b0, 1'b1, 16'h00A5, 16'hBEEF);
        idle_wait("wr_a5");
        req(1'b1, 1'b0, 16'h00A5, 16'h0000);
        chk("a5_busy_t0", {15'd0, out_busy}, 16'h0001);
        @(negedge CLOCK);
        chk("a5_busy_t1", {15'd0, out_busy}, 16'h0001);
        chk("a5_valid_t1", {15'd0, out_rd_valid}, 16'h0000);
        @(negedge CLOCK);
        chk("a5_valid_t2", {15'd0, out_rd_valid}, 16'h0001);
        chk("a5_data", out_rd_data, 16'hBEEF);
        chk("a5_busy_t2", {15'd0, out_busy}, 16'h0000);
        @(negedge CLOCK);
        chk("a5_valid_once", {15'd0, out_rd_valid}, 16'h0000);
        chk("a5_data_hold", out_rd_data, 16'hBEEF);

        // read of cleared word
        do_reset(1'b0);
        req(1'b1, 1'b0, 16'h0003, 16'h0000);
        repeat (2) @(negedge CLOCK);
        chk("r3_valid", {15'd0, out_rd_valid}, 16'h0001);
        chk("r3_data", out_rd_data, 16'h0000);
        chk("r3_err", {15'd0, out_err}, 16'h0000);

        // out-of-range write must not alias onto index 0
        req(1'b0, 1'b1, 16'h0100, 16'h1234);
        repeat (2) @(negedge CLOCK);
        chk("oor_wr_err_early", {15'd0, out_err}, 16'h0000);
        @(negedge CLOCK);
        chk("oor_wr_err", {15'd0, out_err}, 16'h0001);
        req(1'b1, 1'b0, 16'h0000, 16'h0000);
        repeat (2) @(negedge CLOCK);
        chk("oor_wr_nocommit", out_rd_data, 16'h0000);

        // out-of-range read: zero data with valid and err together
        req(1'b0, 1'b1, 16'h0007, 16'h7777);
        idle_wait("wr_7");
        req(1'b1, 1'b0, 16'h0107, 16'h0000);
        repeat (2) @(negedge CLOCK);
        chk("oor_rd_valid", {15'd0, out_rd_valid}, 16'h0001);
        chk("oor_rd_err", {15'd0, out_err}, 16'h0001);
        chk("oor_rd_data", out_rd_data, 16'h0000);

        // conflicting request
        req(1'b1, 1'b1, 16'h0007, 16'h0000);
        chk("both_err", {15'd0, out_err}, 16'h0001);
        chk("both_busy", {15'd0, out_busy}, 16'h0000);
        @(negedge CLOCK);
        chk("both_err_once", {15'd0, out_err}, 16'h0000);
        req(1'b1, 1'b0, 16'h0007, 16'h0000);
        repeat (2) @(negedge CLOCK);
        chk("both_unchanged", out_rd_data, 16'h7777);

        // reset aborts a pending read
        req(1'b1, 1'b0, 16'h0010, 16'h0000);
        in_rst = 1'b1;
        @(negedge CLOCK);
        in_rst = 1'b0;
        chk("abort_busy", {15'd0, out_busy}, 16'h0000);
        chk("abort_valid", {15'd0, out_rd_valid}, 16'h0000);
        chk("abort_data", out_rd_data, 16'h0000);
        @(negedge CLOCK);
        chk("abort_valid_late", {15'd0, out_rd_valid}, 16'h0000);

        // write while busy is dropped
        req(1'b0, 1'b1, 16'h0020, 16'h5555);
        req(1'b0, 1'b1, 16'h0020, 16'hAAAA);
        idle_wait("wr_20");
        req(1'b1, 1'b0, 16'h0020, 16'h0000);
        repeat (2) @(negedge CLOCK);
        chk("busy_wr_ignored", out_rd_data, 16'h5555);

        // random traffic, checked by the per-cycle compare
        for (int it = 0; it < 3000; it++) begin
            int k;
            logic [15:0] a;
            @(negedge CLOCK);
            in_rst = ($urandom_range(0, 63) == 0);
            k = $urandom_range(0, 9);
            a = ($urandom_range(0, 7) == 0) ? (16'($urandom) | 16'h0100) : 16'($urandom_range(0, 15));
            drive(k <= 2 || k == 6, (k >= 3 && k <= 5) || k == 6, a, 16'($urandom));
        end
        @(negedge CLOCK);
        in_rst = 1'b0;
        drive(1'b0, 1'b0, 16'h0000, 16'h0000);
        repeat (12) @(negedge CLOCK);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
